// File: rtl/add_64_sum_collect.sv
// add_64_sum_collect: receiving end of the 6-level pipelined 64-bit KGP prefix adder.
// Issued operands travel down a delay line that matches the prefix pipeline latency.
// When an issued entry reaches the end of that line, its propagate bits are combined
// with the resolved carry vector to form the sum, carry-out and signed overflow. The
// result goes into a small FIFO that feeds a valid/ready consumer. The prefix pipeline
// cannot stall, so issue is throttled by credits. Each credit covers either an
// in-flight operation or a stored result, so every write is guaranteed a free slot.
module add_64_sum_collect #(
  parameter int LATENCY    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  p_in,
  input  logic         cin,
  input  logic [127:0] res_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  sum,
  output logic         cout,
  output logic         ovf,
  output logic         err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic        valid;
    logic [63:0] p;
    logic        cin;
  } dly_t;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  dly_t             r_dly [LATENCY];
  res_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_credits;
  logic             r_err;

  dly_t             w_head;
  logic [63:0]      w_carry;
  logic [63:0]      w_unres;
  res_t             w_result;
  logic             w_issue;
  logic             w_pop;
  logic             w_wr;

  // Circular pointer advance. The explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign in_ready  = (r_credits != '0);
  assign out_valid = (r_count != '0);
  assign w_issue   = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_head    = r_dly[LATENCY-1];
  assign w_wr      = w_head.valid;

  // Resolve each KGP pair to a carry. Bit 1 of the pair is the carry for 11 and 00.
  // It is also the carry for an unresolved pair, which additionally raises err.
  always_comb begin
    // NOTE: every output gets a value on every path through always_comb, so no latch is inferred.
    w_carry = '0;
    w_unres = '0;
    for (int i = 0; i < 64; i++) begin
      w_carry[i] = res_in[2*i+1];
      w_unres[i] = res_in[2*i+1] ^ res_in[2*i];
    end
    w_result.sum  = w_head.p ^ {w_carry[62:0], w_head.cin};
    w_result.cout = w_carry[63];
    w_result.ovf  = w_carry[63] ^ w_carry[62];
  end

  // Delay line that tracks issued operands until their carries arrive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) r_dly[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read the value from before this edge.
      r_dly[0] <= '{valid: w_issue, p: p_in, cin: cin};
      for (int i = 1; i < LATENCY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  // Result FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is reset on purpose. The head drives sum/cout/ovf directly,
      // and those outputs must read zero after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_result;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Credits: one is taken on issue and one is returned when a result is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credits <= CNT_W'(FIFO_DEPTH);
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Sticky error: an unresolved pair was captured with a live entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_wr && (w_unres != '0)) begin
      r_err <= 1'b1;
    end
  end

  assign sum  = r_mem[r_rd_ptr].sum;
  assign cout = r_mem[r_rd_ptr].cout;
  assign ovf  = r_mem[r_rd_ptr].ovf;
  assign err  = r_err;

endmodule

// File: tb/tb_add_64_sum_collect.sv
// tb_add_64_sum_collect: randomized and directed bench for add_64_sum_collect.
// The reference model builds the carry vector from operands a and b using plain
// addition. The expected sum is a+b+cin, and the expected overflow comes from the
// operand and result signs.
module tb_add_64_sum_collect;

  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  p_in;
  logic         cin;
  logic [127:0] res_in;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  sum;
  logic         cout;
  logic         ovf;
  logic         err;

  always #5 clk = ~clk;

  add_64_sum_collect #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .p_in(p_in), .cin(cin), .res_in(res_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .err(err)
  );

  typedef struct {
    logic [63:0]  p;
    logic         cin;
    logic [127:0] res;
    logic [63:0]  sum;
    logic         cout;
    logic         ovf;
    int           icyc;
  } op_t;

  op_t          exp_q[$];
  logic [127:0] sched[int];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  bit           lat_chk = 1'b0;
  bit           dummy;

  function automatic op_t zero_op();
    op_t o;
    o.p = '0; o.cin = 1'b0; o.res = '0; o.sum = '0; o.cout = 1'b0; o.ovf = 1'b0; o.icyc = 0;
    return o;
  endfunction

  // Reference: carries are bits of the partial sums of the low i+1 bits.
  function automatic op_t make_op(input logic [63:0] a, input logic [63:0] b, input logic ci);
    op_t         o;
    logic [64:0] full;
    logic [64:0] mask;
    logic [64:0] part;
    o      = zero_op();
    full   = {1'b0, a} + {1'b0, b} + {64'd0, ci};
    o.p    = a ^ b;
    o.cin  = ci;
    for (int i = 0; i < 64; i++) begin
      mask = (65'd1 << (i + 1)) - 65'd1;
      part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {64'd0, ci};
      o.res[2*i+:2] = {part[i+1], part[i+1]};
    end
    o.sum  = full[63:0];
    o.cout = full[64];
    o.ovf  = (a[63] == b[63]) && (full[63] != a[63]);
    return o;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'h0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      3:       v = 64'h8000_0000_0000_0000;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  // One clock cycle, entered and left at posedge+1. It drives the inputs, supplies
  // the scheduled carries (or junk when nothing is due), scores any pop, then advances.
  task automatic run_cycle(input bit v, input op_t op, input bit rdy, output bit issued);
    op_t e;
    in_valid  = v;
    p_in      = op.p;
    cin       = op.cin;
    out_ready = rdy;
    res_in    = sched.exists(cyc) ? sched[cyc] : {$urandom(), $urandom(), $urandom(), $urandom()};
    if (lat_chk && exp_q.size() > 0 && exp_q[0].icyc + LAT + 1 == cyc) begin
      n_tests++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL latency_valid: out_valid=%b expected 1 at cycle %0d", out_valid, cyc);
      end
    end
    if (out_valid === 1'b1 && rdy) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: sum=%h with no result outstanding", sum);
      end else begin
        e = exp_q.pop_front();
        if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
          n_fail++;
          $display("FAIL result: sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                   sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        if (lat_chk) begin
          n_tests++;
          if (cyc != e.icyc + LAT + 1) begin
            n_fail++;
            $display("FAIL latency: popped at %0d expected %0d", cyc, e.icyc + LAT + 1);
          end
        end
      end
    end
    issued = v && (in_ready === 1'b1);
    if (issued) begin
      e = op;
      e.icyc = cyc;
      sched[cyc + LAT] = op.res;
      exp_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input bit rdy);
    run_cycle(1'b0, zero_op(), rdy, dummy);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    sched.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; p_in = '0; cin = 1'b0; res_in = '0;
    reset = 1'b1;
    #2;
    n_tests++;
    if ({out_valid, in_ready, sum, cout, ovf, err} !== {1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b err=%b expected 0 1 0 0 0 0",
               out_valid, in_ready, sum, cout, ovf, err);
    end
    do_reset();
  endtask

  // A lone op: out_valid stays low for LATENCY cycles, rises at +6, and holds under back-pressure.
  task automatic single_op(input string name, input op_t op);
    bit iss;
    run_cycle(1'b1, op, 1'b0, iss);
    n_tests++;
    if (!iss) begin n_fail++; $display("FAIL %s_issue: in_ready=%b expected 1", name, in_ready); end
    for (int k = 1; k <= LAT; k++) begin
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_early: out_valid=%b expected 0 at +%0d", name, out_valid, k);
      end
      idle(1'b0);
    end
    idle(1'b0);
    n_tests++;
    if ({out_valid, sum, cout, ovf} !== {1'b1, op.sum, op.cout, op.ovf}) begin
      n_fail++;
      $display("FAIL %s_hold: out_valid=%b sum=%h cout=%b ovf=%b expected 1 %h %b %b",
               name, out_valid, sum, cout, ovf, op.sum, op.cout, op.ovf);
    end
    idle(1'b1);
    n_tests++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: out_valid=%b outstanding=%0d expected 0 0", name, out_valid, exp_q.size());
    end
  endtask

  task automatic test_single();
    op_t o;
    o = zero_op();
    o.p = 64'hFFFF_FFFF_FFFF_FFFF; o.cin = 1'b1; o.res = {128{1'b1}};
    o.sum = 64'h0; o.cout = 1'b1; o.ovf = 1'b0;
    single_op("single", o);
  endtask

  task automatic test_overflow();
    op_t o;
    o = zero_op();
    o.res[125:124] = 2'b11;
    o.sum = 64'h8000_0000_0000_0000; o.cout = 1'b0; o.ovf = 1'b1;
    single_op("overflow", o);
  endtask

  task automatic test_random();
    bit iss;
    for (int i = 0; i < 60; i++)
      run_cycle(1'($urandom_range(0, 1)), make_op(rnd64(), rnd64(), 1'($urandom_range(0, 1))),
                1'($urandom_range(0, 1)), iss);
    for (int i = 0; i < 20; i++) idle(1'b1);
    n_tests++;
    if (exp_q.size() != 0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: outstanding=%0d err=%b expected 0 0", exp_q.size(), err);
    end
  endtask

  task automatic test_backpressure();
    bit iss;
    int accepted = 0;
    for (int i = 0; i < 14; i++) begin
      run_cycle(1'b1, make_op(rnd64(), rnd64(), 1'($urandom_range(0, 1))), 1'b0, iss);
      if (iss) accepted++;
    end
    n_tests++;
    if (accepted != DEPTH || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b expected %0d 0", accepted, in_ready, DEPTH);
    end
    for (int i = 0; i < 20; i++) idle(1'b1);
    n_tests++;
    if (exp_q.size() != 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain: outstanding=%0d in_ready=%b expected 0 1", exp_q.size(), in_ready);
    end
  endtask

  task automatic test_streaming();
    bit iss;
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      run_cycle(1'b1, make_op({32'(i), $urandom()}, rnd64(), 1'($urandom_range(0, 1))), 1'b1, iss);
      n_tests++;
      if (!iss) begin n_fail++; $display("FAIL stream_ready: in_ready=0 at op %0d expected 1", i); end
    end
    for (int i = 0; i < 10; i++) idle(1'b1);
    lat_chk = 1'b0;
    n_tests++;
    if (exp_q.size() != 0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: outstanding=%0d err=%b expected 0 0", exp_q.size(), err);
    end
  endtask

  task automatic test_unresolved();
    op_t o;
    bit  iss;
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL unres_pre: err=%b expected 0", err); end
    o = zero_op();
    o.res[21:20] = 2'b01;
    run_cycle(1'b1, o, 1'b1, iss);
    o = zero_op();
    o.res[41:40] = 2'b10;
    o.sum = 64'h0000_0000_0020_0000;
    run_cycle(1'b1, o, 1'b1, iss);
    for (int i = 0; i < 8; i++) idle(1'b1);
    n_tests++;
    if (err !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL unres_set: err=%b outstanding=%0d expected 1 0", err, exp_q.size());
    end
    for (int i = 0; i < 20; i++)
      run_cycle(1'b1, make_op(rnd64(), rnd64(), 1'($urandom_range(0, 1))), 1'b1, iss);
    for (int i = 0; i < 10; i++) idle(1'b1);
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL unres_sticky: err=%b expected 1", err); end
  endtask

  task automatic test_reset_midflight();
    bit iss;
    int accepted = 0;
    for (int i = 0; i < 5; i++) run_cycle(1'b1, make_op(rnd64(), rnd64(), 1'b0), 1'b0, iss);
    idle(1'b0);
    idle(1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: out_valid=%b in_ready=%b expected 1 1", out_valid, in_ready);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, in_ready, sum, cout, ovf, err} !== {1'b1 ^ 1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b err=%b expected 0 1 0 0 0 0",
               out_valid, in_ready, sum, cout, ovf, err);
    end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b1, make_op(rnd64(), rnd64(), 1'($urandom_range(0, 1))), 1'b0, iss);
      if (iss) accepted++;
    end
    n_tests++;
    if (accepted != DEPTH) begin
      n_fail++;
      $display("FAIL mid_credits: accepted=%0d expected %0d", accepted, DEPTH);
    end
    for (int i = 0; i < 20; i++) idle(1'b1);
    n_tests++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_drain: outstanding=%0d out_valid=%b in_ready=%b expected 0 0 1",
               exp_q.size(), out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_random();
    test_backpressure();
    test_streaming();
    test_unresolved();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
